// File: rtl/linebuffer_window.sv
// linebuffer_window: RAM-based line buffer producing a vertical column of WIN
// pixels per accepted input pixel, for 2D filters in the camera->LCD path.
// The previous WIN-1 lines live in per-line circular RAMs addressed by column.
// Ports:
//   in_clk, rst_n (synchronous, active-low)
//   line_len  pixels per line, latched on an accepted in_sof pixel (0 / >MAX_LINE -> MAX_LINE)
//   in_sof, in_de, in_data  input pixel stream
//   out_valid, out_data (tap k at [k*DATA_WIDTH +: DATA_WIDTH], k rows above), out_col, out_full
// Build option: define LINEBUF_BORDER_REPLICATE_EN to replicate the top border into
// taps above the frame; otherwise those taps read as zero.
module linebuffer_window #(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned MAX_LINE   = 1024,
    parameter  int unsigned WIN        = 3,
    localparam int unsigned ADDR_W     = $clog2(MAX_LINE)
) (
    input  logic                       in_clk,
    input  logic                       rst_n,
    input  logic [ADDR_W:0]            line_len,
    input  logic                       in_sof,
    input  logic                       in_de,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    output logic [WIN*DATA_WIDTH-1:0]  out_data,
    output logic [ADDR_W-1:0]          out_col,
    output logic                       out_full
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned ROW_W = $clog2(WIN);
    localparam int unsigned NRAM  = WIN - 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_LINE);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(WIN - 1);

    logic [ADDR_W-1:0]         col_q, col_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic                      out_valid_q, out_valid_d;
    logic [WIN*DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0]         out_col_q, out_col_d;
    logic                      out_full_q, out_full_d;

    logic                  sof_acc;
    logic [LEN_W-1:0]      len_in;
    logic [LEN_W-1:0]      len_eff;
    logic [ADDR_W-1:0]     col_eff;
    logic [ROW_W-1:0]      row_eff;
    logic                  line_end;
    logic [DATA_WIDTH-1:0] ram_rd [NRAM];
    logic [DATA_WIDTH-1:0] tap    [WIN];

    // Effective position of the pixel on the bus: an accepted SOF restarts the frame
    always_comb begin
        sof_acc  = in_sof & in_de;
        len_in   = ((line_len == '0) || (line_len > MAX_LEN)) ? MAX_LEN : line_len;
        len_eff  = sof_acc ? len_in : len_q;
        col_eff  = sof_acc ? '0 : col_q;
        row_eff  = sof_acc ? '0 : row_q;
        line_end = ({1'b0, col_eff} == (len_eff - LEN_W'(1)));
    end

    // Line RAMs: asynchronous read of the old value, cascaded write at the same column
    for (genvar j = 0; j < NRAM; j++) begin : g_line
        logic [DATA_WIDTH-1:0] mem [MAX_LINE];
        logic [DATA_WIDTH-1:0] wr_data;

        if (j == 0) begin : g_first
            assign wr_data = in_data;
        end else begin : g_cascade
            assign wr_data = ram_rd[j-1];
        end

        assign ram_rd[j] = mem[col_eff];

        always_ff @(posedge in_clk) begin
            if (rst_n && in_de) begin
                mem[col_eff] <= wr_data;
            end
        end
    end

    // Tap 0 is the live pixel, tap k is the value stored k lines back
    always_comb begin
        tap[0] = in_data;
        for (int unsigned k = 1; k < WIN; k++) begin
            tap[k] = ram_rd[k-1];
        end
    end

    // Next-state and registered output values
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        len_d       = len_q;
        out_valid_d = in_de;
        out_data_d  = out_data_q;
        out_col_d   = out_col_q;
        out_full_d  = out_full_q;

        if (in_de) begin
            len_d = len_eff;
            if (line_end) begin
                col_d = '0;
                row_d = (row_eff >= ROW_MAX) ? ROW_MAX : row_eff + ROW_W'(1);
            end else begin
                col_d = col_eff + ADDR_W'(1);
                row_d = row_eff;
            end

            out_col_d  = col_eff;
            out_full_d = (row_eff >= ROW_MAX);

            // Taps reaching above the first frame row hold stale RAM; substitute them
            for (int unsigned k = 0; k < WIN; k++) begin
                if (k > 32'(row_eff)) begin
`ifdef LINEBUF_BORDER_REPLICATE_EN
                    out_data_d[k*DATA_WIDTH +: DATA_WIDTH] = tap[row_eff];
`else
                    out_data_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
`endif
                end else begin
                    out_data_d[k*DATA_WIDTH +: DATA_WIDTH] = tap[k];
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge in_clk) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            len_q       <= MAX_LEN;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_col_q   <= '0;
            out_full_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_col_q   <= out_col_d;
            out_full_q  <= out_full_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_col   = out_col_q;
    assign out_full  = out_full_q;

endmodule

// File: tb/tb_linebuffer_window.sv
// Testbench for linebuffer_window (WIN=3, DATA_WIDTH=8, MAX_LINE=1024).
// Expected columns are built from a record of every pixel driven in the current
// frame and queued at drive time; they are popped when out_valid is seen.
module tb_linebuffer_window;

    localparam int unsigned DW  = 8;
    localparam int unsigned ML  = 1024;
    localparam int unsigned WIN = 3;
    localparam int unsigned AW  = 10;

    logic              in_clk;
    logic              rst_n;
    logic [AW:0]       line_len;
    logic              in_sof;
    logic              in_de;
    logic [DW-1:0]     in_data;
    logic              out_valid;
    logic [WIN*DW-1:0] out_data;
    logic [AW-1:0]     out_col;
    logic              out_full;

    linebuffer_window #(
        .DATA_WIDTH (DW),
        .MAX_LINE   (ML),
        .WIN        (WIN)
    ) dut (
        .in_clk    (in_clk),
        .rst_n     (rst_n),
        .line_len  (line_len),
        .in_sof    (in_sof),
        .in_de     (in_de),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_col   (out_col),
        .out_full  (out_full)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic [WIN*DW-1:0] data;
        logic [AW-1:0]     col;
        logic              full;
    } exp_t;

    exp_t              sb_q[$];
    logic [DW-1:0]     frame_px [16][ML];
    int unsigned       m_len;
    int unsigned       m_col;
    int unsigned       m_row;
    logic              exp_valid;
    logic [WIN*DW-1:0] last_data;
    logic [AW-1:0]     last_col;
    logic              last_full;
    int                n_checks;
    int                n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected column: tap k is the pixel k rows above in this frame
    function automatic logic [WIN*DW-1:0] model_taps();
        logic [WIN*DW-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < WIN; k++) begin
            if (k <= m_row) begin
                r[k*DW +: DW] = frame_px[(m_row - k) % 16][m_col];
            end else begin
`ifdef LINEBUF_BORDER_REPLICATE_EN
                r[k*DW +: DW] = frame_px[0][m_col];
`else
                r[k*DW +: DW] = '0;
`endif
            end
        end
        return r;
    endfunction

    // One clock of stimulus followed by the output check for that cycle
    task automatic step(input logic rst, input logic de, input logic sof,
                        input logic [DW-1:0] d, input logic [AW:0] len);
        exp_t        e;
        int unsigned lv;
        rst_n    = rst;
        in_de    = de;
        in_sof   = sof;
        in_data  = d;
        line_len = len;
        if (!rst) begin
            m_len     = ML;
            m_col     = 0;
            m_row     = 0;
            exp_valid = 1'b0;
            last_data = '0;
            last_col  = '0;
            last_full = 1'b0;
        end else if (de) begin
            if (sof) begin
                lv    = 32'(len);
                m_len = ((lv == 0) || (lv > ML)) ? ML : lv;
                m_col = 0;
                m_row = 0;
            end
            frame_px[m_row % 16][m_col] = d;
            e.data = model_taps();
            e.col  = AW'(m_col);
            e.full = (m_row >= WIN - 1);
            sb_q.push_back(e);
            if (m_col == m_len - 1) begin
                m_col = 0;
                m_row++;
            end else begin
                m_col++;
            end
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        @(posedge in_clk);
        @(negedge in_clk);
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        if (out_valid) begin
            check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("out_data", 64'(out_data), 64'(e.data));
                check("out_col", 64'(out_col), 64'(e.col));
                check("out_full", 64'(out_full), 64'(e.full));
                last_data = e.data;
                last_col  = e.col;
                last_full = e.full;
            end
        end else begin
            check("hold_data", 64'(out_data), 64'(last_data));
            check("hold_col", 64'(out_col), 64'(last_col));
            check("hold_full", 64'(out_full), 64'(last_full));
        end
    endtask

    // Idle cycles with junk on the data/sof/len inputs, which must be ignored
    task automatic gap(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)), DW'($urandom), (AW+1)'($urandom));
        end
    endtask

    // Whole frame, ramp data, optional random de gaps inside lines
    task automatic frame(input int unsigned len, input int unsigned rows,
                         input int unsigned seed, input bit gaps);
        for (int unsigned r = 0; r < rows; r++) begin
            for (int unsigned c = 0; c < len; c++) begin
                if (gaps && ($urandom_range(0, 3) == 0)) gap($urandom_range(1, 50));
                step(1'b1, 1'b1, (r == 0) && (c == 0), DW'(seed + r * 16 + c), (AW+1)'(len));
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_de     = 1'b0;
        in_sof    = 1'b0;
        in_data   = '0;
        line_len  = '0;
        exp_valid = 1'b0;
        last_data = '0;
        last_col  = '0;
        last_full = 1'b0;
        m_len     = ML;
        m_col     = 0;
        m_row     = 0;

        // Reset values
        step(1'b0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0);
        gap(2);

        // Ramp row*16+col, line_len 4, three rows gapless then with gaps
        frame(4, 3, 0, 1'b0);
        gap(3);
        frame(4, 3, 0, 1'b1);
        gap(2);

        // line_len 0 clamps to 1024, then 5, then an oversize length
        for (int unsigned i = 0; i < ML + 2; i++) begin
            step(1'b1, 1'b1, i == 0, DW'(i ^ 32'h5A), (i == 0) ? '0 : (AW+1)'(7));
        end
        frame(5, 2, 8'h40, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h77, (AW+1)'(3));
        for (int unsigned i = 0; i < ML + 1; i++) begin
            step(1'b1, 1'b1, i == 0, DW'(i * 3), (AW+1)'(1500));
        end
        gap(1);

        // SOF at column 2 of row 2 abandons the line and restarts the frame
        for (int unsigned i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, i == 0, DW'(8'h80 + i), (AW+1)'(4));
        end
        frame(4, 3, 8'hA0, 1'b0);

        // Reset for one cycle mid-line, then resume without SOF
        for (int unsigned i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, i == 0, DW'(8'hC0 + i), (AW+1)'(4));
        end
        step(1'b0, 1'b1, 1'b0, 8'hEE, (AW+1)'(4));
        for (int unsigned i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0, DW'($urandom), (AW+1)'(4));
        end
        gap(2);

        // Random data, length 6, five rows with gaps
        for (int unsigned i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 0) gap($urandom_range(1, 5));
            step(1'b1, 1'b1, i == 0, DW'($urandom), (AW+1)'(6));
        end
        gap(2);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
